// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters.
// Latches the winner's operands, drives the ALU for one cycle, and captures result/flags.
module alu_arbiter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned FUNC_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [WIDTH-1:0]  a0,
   input  logic [WIDTH-1:0]  a1,
   input  logic [WIDTH-1:0]  b0,
   input  logic [WIDTH-1:0]  b1,
   input  logic [FUNC_W-1:0] func0,
   input  logic [FUNC_W-1:0] func1,
   input  logic              ci0,
   input  logic              ci1,
   input  logic              fwe0,
   input  logic              fwe1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [WIDTH-1:0]  result,
   output logic              flag_c,
   output logic              flag_z,
   output logic              flag_n,
   output logic              busy,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [FUNC_W-1:0] alu_func,
   output logic              alu_ci,
   input  logic [WIDTH-1:0]  alu_res,
   input  logic              alu_co,
   input  logic              alu_z,
   input  logic              alu_n
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic                last_q,   last_d;
   logic                port_q,   port_d;
   logic                fwe_q,    fwe_d;
   logic                gnt0_q,   gnt0_d;
   logic                gnt1_q,   gnt1_d;
   logic                done0_q,  done0_d;
   logic                done1_q,  done1_d;
   logic                busy_q,   busy_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic                fc_q,     fc_d;
   logic                fz_q,     fz_d;
   logic                fn_q,     fn_d;
   logic [WIDTH-1:0]    alu_a_q,  alu_a_d;
   logic [WIDTH-1:0]    alu_b_q,  alu_b_d;
   logic [FUNC_W-1:0]   alu_f_q,  alu_f_d;
   logic                alu_ci_q, alu_ci_d;
   logic                win1_c;

   // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
   assign win1_c = req1 && (!req0 || !last_q);

   // Next-state and output logic; the alu_* registers double as the latched op operands.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      port_d   = port_q;
      fwe_d    = fwe_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      result_d = result_q;
      fc_d     = fc_q;
      fz_d     = fz_q;
      fn_d     = fn_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_f_d  = alu_f_q;
      alu_ci_d = alu_ci_q;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               port_d   = win1_c;
               last_d   = win1_c;
               gnt0_d   = !win1_c;
               gnt1_d   = win1_c;
               alu_a_d  = win1_c ? a1    : a0;
               alu_b_d  = win1_c ? b1    : b0;
               alu_f_d  = win1_c ? func1 : func0;
               alu_ci_d = win1_c ? ci1   : ci0;
               fwe_d    = win1_c ? fwe1  : fwe0;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_res;
            if (fwe_q) begin
               fc_d = alu_co;
               fz_d = alu_z;
               fn_d = alu_n;
            end
            done0_d = !port_q;
            done1_d = port_q;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         port_q   <= 1'b0;
         fwe_q    <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
         fc_q     <= 1'b0;
         fz_q     <= 1'b0;
         fn_q     <= 1'b0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_f_q  <= '0;
         alu_ci_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         port_q   <= port_d;
         fwe_q    <= fwe_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
         result_q <= result_d;
         fc_q     <= fc_d;
         fz_q     <= fz_d;
         fn_q     <= fn_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_f_q  <= alu_f_d;
         alu_ci_q <= alu_ci_d;
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign busy     = busy_q;
   assign result   = result_q;
   assign flag_c   = fc_q;
   assign flag_z   = fz_q;
   assign flag_n   = fn_q;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_func = alu_f_q;
   assign alu_ci   = alu_ci_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an adder ALU stub and directed, hand-computed vectors.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [7:0] a0, a1, b0, b1;
   logic [2:0] func0, func1;
   logic       ci0, ci1, fwe0, fwe1;
   logic       gnt0, gnt1, done0, done1;
   logic [7:0] result;
   logic       flag_c, flag_z, flag_n, busy;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_func;
   logic       alu_ci;
   logic [7:0] alu_res;
   logic       alu_co, alu_z, alu_n;

   typedef struct packed {
      logic       port;
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       n;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   assign {alu_co, alu_res} = 9'({1'b0, alu_a}) + 9'({1'b0, alu_b}) + 9'(alu_ci);
   assign alu_z = (alu_res == 8'h00);
   assign alu_n = alu_res[7];

   alu_arbiter #(.WIDTH(8), .FUNC_W(3)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .func0(func0), .func1(func1),
      .ci0(ci0), .ci1(ci1), .fwe0(fwe0), .fwe1(fwe1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
      .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_ci(alu_ci),
      .alu_res(alu_res), .alu_co(alu_co), .alu_z(alu_z), .alu_n(alu_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expected completion whenever the DUT signals done.
   always @(negedge clk) begin
      check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
      if (done0 || done1) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", 32'({done1, done0}), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_port", 32'({done1, done0}), e.port ? 32'd2 : 32'd1);
            check("result", 32'(result), 32'(e.res));
            check("flags_czn", 32'({flag_c, flag_z, flag_n}), 32'({e.c, e.z, e.n}));
         end
      end
   end

   task automatic set_port(input logic p, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic fwe);
      if (p) begin a1 = a; b1 = b; ci1 = ci; fwe1 = fwe; func1 = 3'd1; req1 = 1'b1; end
      else   begin a0 = a; b0 = b; ci0 = ci; fwe0 = fwe; func0 = 3'd0; req0 = 1'b1; end
   endtask

   // One op from a single requester; optionally changes operand A during EXEC.
   task automatic run_op(input logic p, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic fwe, input logic [7:0] er,
                         input logic ec, input logic ez, input logic en, input logic poke_a);
      set_port(p, a, b, ci, fwe);
      exp_q.push_back('{port: p, res: er, c: ec, z: ez, n: en});
      @(posedge clk); @(negedge clk);
      check("gnt_latency", 32'({gnt1, gnt0}), p ? 32'd2 : 32'd1);
      check("busy_exec", 32'(busy), 32'd1);
      check("alu_a_drive", 32'(alu_a), 32'(a));
      if (poke_a) begin
         if (p) a1 = 8'h00; else a0 = 8'h00;
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); @(negedge clk);
      check("done_latency", 32'({done1, done0}), p ? 32'd2 : 32'd1);
      @(posedge clk); @(negedge clk);
      check("done_clear", 32'({done1, done0}), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; a1 = '0; b0 = '0; b1 = '0; func0 = '0; func1 = '0;
      ci0 = 1'b0; ci1 = 1'b0; fwe0 = 1'b0; fwe1 = 1'b0;

      // Test 1: reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt_done", 32'({gnt0, gnt1, done0, done1}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
      check("rst_alu", 32'({alu_a, alu_b, alu_func, alu_ci}), 32'd0);
      rst = 1'b0;

      // Test 2: 0x79 + 0x84 + 1 = 0xFE
      run_op(1'b0, 8'h79, 8'h84, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
      // Test 3: 0xFF + 0x01 = 0x00 without flag write
      run_op(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Test 4: continuous contention, strict alternation every 3 cycles
      set_port(1'b0, 8'h01, 8'h02, 1'b0, 1'b1);
      set_port(1'b1, 8'h10, 8'hF0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back('{port: 1'b0, res: 8'h03, c: 1'b0, z: 1'b0, n: 1'b0});
         exp_q.push_back('{port: 1'b1, res: 8'h00, c: 1'b1, z: 1'b1, n: 1'b0});
      end
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); @(negedge clk);
         check("rr_gnt0", 32'(gnt0), (i == 0 || i == 6) ? 32'd1 : 32'd0);
         check("rr_gnt1", 32'(gnt1), (i == 3 || i == 9) ? 32'd1 : 32'd0);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rr_drained", 32'(exp_q.size()), 32'd0);
      check("rr_no_regrant", 32'({gnt0, gnt1}), 32'd0);

      // Test 5: reset during EXEC discards the op
      set_port(1'b0, 8'h80, 8'h80, 1'b0, 1'b1);
      @(posedge clk); @(negedge clk);
      check("t5_gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      rst  = 1'b1;
      @(posedge clk); @(negedge clk);
      check("t5_no_done", 32'({done0, done1}), 32'd0);
      check("t5_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
      check("t5_result", 32'(result), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_alu", 32'({alu_a, alu_b}), 32'd0);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("t5_idle_no_done", 32'({done0, done1}), 32'd0);
      run_op(1'b0, 8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

      // Test 6: operand change after grant has no effect
      run_op(1'b0, 8'h10, 8'h05, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset restores port 0 priority even though port 0 was served last
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      set_port(1'b0, 8'h22, 8'h11, 1'b1, 1'b0);
      set_port(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
      exp_q.push_back('{port: 1'b0, res: 8'h34, c: 1'b0, z: 1'b0, n: 1'b0});
      @(posedge clk); @(negedge clk);
      check("tie_after_rst", 32'({gnt1, gnt0}), 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      check("final_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
